// File: rtl/ipsxb_ddr_rst_pkg.sv
// Shared constants for the DDR reset sequencer: state encoding, default cycle counts, counter sizing.
package ipsxb_ddr_rst_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_LOCK   = 3'd0,
      ST_LOCK_STABLE = 3'd1,
      ST_PHY_WAIT    = 3'd2,
      ST_CTRL_WAIT   = 3'd3,
      ST_USER_DLY    = 3'd4,
      ST_DONE        = 3'd5,
      ST_ERR         = 3'd6
   } seq_state_e;

   localparam int unsigned SEQ_STATE_W         = 3;
   localparam int unsigned DEF_LOCK_STABLE_CYC = 16;
   localparam int unsigned DEF_USER_DLY_CYC    = 8;
   localparam int unsigned DEF_TIMEOUT_CYC     = 1024;
   localparam int unsigned DEF_CNT_W           = 16;

   // Bits needed for a counter that must reach (max of the three cycle counts) - 1.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                             input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/ipsxb_ddr_rst_seq.sv
// DDR reset sequencer: debounces PLL lock, then releases PHY, controller and user resets in order,
// with per-stage init-done timeouts. Lock loss restarts the whole sequence.
module ipsxb_ddr_rst_seq
   import ipsxb_ddr_rst_pkg::*;
#(
   parameter int unsigned LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
   parameter int unsigned USER_DLY_CYC    = DEF_USER_DLY_CYC,
   parameter int unsigned TIMEOUT_CYC     = DEF_TIMEOUT_CYC,
   parameter int unsigned CNT_W           = DEF_CNT_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   pll_lock,
   input  logic                   phy_init_done,
   input  logic                   ctrl_init_done,
   output logic                   phy_rst_n,
   output logic                   ctrl_rst_n,
   output logic                   user_rst_n,
   output logic                   ddr_init_done,
   output logic                   init_err,
   output logic [SEQ_STATE_W-1:0] seq_state
);

   // Elaboration guard: the counter must be able to reach every terminal count.
   if (CNT_W < cnt_width(LOCK_STABLE_CYC, USER_DLY_CYC, TIMEOUT_CYC)) begin : g_cnt_w_chk
      $error("CNT_W too small for the configured cycle counts");
   end

   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [CNT_W-1:0] USER_LAST = CNT_W'(USER_DLY_CYC - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);

   seq_state_e       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             phy_rst_n_nxt, ctrl_rst_n_nxt, user_rst_n_nxt, init_err_nxt;

   // Next-state, counter and output decode (outputs decoded from next state so registers track state).
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      phy_rst_n_nxt  = 1'b0;
      ctrl_rst_n_nxt = 1'b0;
      user_rst_n_nxt = 1'b0;
      init_err_nxt   = 1'b0;

      if (state != ST_WAIT_LOCK && !pll_lock) begin
         state_nxt = ST_WAIT_LOCK;
      end else begin
         unique case (state)
            ST_WAIT_LOCK:   if (pll_lock) state_nxt = ST_LOCK_STABLE;
            ST_LOCK_STABLE: if (cnt == LOCK_LAST) state_nxt = ST_PHY_WAIT;
            ST_PHY_WAIT: begin
               if (phy_init_done)       state_nxt = ST_CTRL_WAIT;
               else if (cnt == TO_LAST) state_nxt = ST_ERR;
            end
            ST_CTRL_WAIT: begin
               if (ctrl_init_done)      state_nxt = ST_USER_DLY;
               else if (cnt == TO_LAST) state_nxt = ST_ERR;
            end
            ST_USER_DLY:    if (cnt == USER_LAST) state_nxt = ST_DONE;
            ST_DONE:        state_nxt = ST_DONE;
            ST_ERR:         state_nxt = ST_ERR;
            default:        state_nxt = ST_WAIT_LOCK;
         endcase
      end

      if (state_nxt != state) begin
         cnt_nxt = '0;
      end else if (state == ST_LOCK_STABLE || state == ST_PHY_WAIT ||
                   state == ST_CTRL_WAIT   || state == ST_USER_DLY) begin
         cnt_nxt = cnt + CNT_W'(1);
      end

      unique case (state_nxt)
         ST_PHY_WAIT:  phy_rst_n_nxt = 1'b1;
         ST_CTRL_WAIT,
         ST_USER_DLY: begin
            phy_rst_n_nxt  = 1'b1;
            ctrl_rst_n_nxt = 1'b1;
         end
         ST_DONE: begin
            phy_rst_n_nxt  = 1'b1;
            ctrl_rst_n_nxt = 1'b1;
            user_rst_n_nxt = 1'b1;
         end
         ST_ERR:       init_err_nxt = 1'b1;
         default:      ;
      endcase
   end

   // State, counter and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= ST_WAIT_LOCK;
         cnt           <= '0;
         phy_rst_n     <= 1'b0;
         ctrl_rst_n    <= 1'b0;
         user_rst_n    <= 1'b0;
         ddr_init_done <= 1'b0;
         init_err      <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         phy_rst_n     <= phy_rst_n_nxt;
         ctrl_rst_n    <= ctrl_rst_n_nxt;
         user_rst_n    <= user_rst_n_nxt;
         ddr_init_done <= user_rst_n_nxt;
         init_err      <= init_err_nxt;
      end
   end

   assign seq_state = SEQ_STATE_W'(state);

endmodule

// File: tb/tb_ipsxb_ddr_rst_seq.sv
// Self-checking bench for ipsxb_ddr_rst_seq: vector table, hand-written corner sequences, random run.
module tb_ipsxb_ddr_rst_seq;

   localparam int LS = 16;
   localparam int UD = 8;
   localparam int TO = 32;

   logic       clk = 1'b0;
   logic       rst_n, pll_lock, phy_init_done, ctrl_init_done;
   logic       phy_rst_n, ctrl_rst_n, user_rst_n, ddr_init_done, init_err;
   logic [2:0] seq_state;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   ipsxb_ddr_rst_seq #(
      .LOCK_STABLE_CYC(LS), .USER_DLY_CYC(UD), .TIMEOUT_CYC(TO), .CNT_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .phy_init_done(phy_init_done),
      .ctrl_init_done(ctrl_init_done), .phy_rst_n(phy_rst_n), .ctrl_rst_n(ctrl_rst_n),
      .user_rst_n(user_rst_n), .ddr_init_done(ddr_init_done), .init_err(init_err),
      .seq_state(seq_state)
   );

   // Reference model: phase number and how many edges it has been occupied.
   int m_phase = 0;
   int m_el    = 0;

   task automatic model_step();
      int nxt;
      nxt = m_phase;
      if (!rst_n) nxt = 0;
      else if (m_phase != 0 && !pll_lock) nxt = 0;
      else if (m_phase == 0 && pll_lock) nxt = 1;
      else if (m_phase == 1 && m_el == LS - 1) nxt = 2;
      else if (m_phase == 2 && phy_init_done) nxt = 3;
      else if (m_phase == 3 && ctrl_init_done) nxt = 4;
      else if ((m_phase == 2 || m_phase == 3) && m_el == TO - 1) nxt = 6;
      else if (m_phase == 4 && m_el == UD - 1) nxt = 5;
      if (!rst_n || nxt != m_phase) m_el = 0;
      else m_el = m_el + 1;
      m_phase = nxt;
   endtask

   function automatic logic [7:0] model_outs();
      logic [7:0] o;
      o[7:5] = 3'(m_phase);
      o[4]   = (m_phase >= 2 && m_phase <= 5);
      o[3]   = (m_phase >= 3 && m_phase <= 5);
      o[2]   = (m_phase == 5);
      o[1]   = (m_phase == 5);
      o[0]   = (m_phase == 6);
      return o;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic l, input logic p, input logic c);
      rst_n = r; pll_lock = l; phy_init_done = p; ctrl_init_done = c;
   endtask

   // One clock: model follows the edge, then every output is compared at the falling edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("model", int'({seq_state, phy_rst_n, ctrl_rst_n, user_rst_n, ddr_init_done, init_err}),
          int'(model_outs()));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk_outs(input string name, input int st, input logic [4:0] o);
      chk({name, "_state"}, int'(seq_state), st);
      chk({name, "_outs"}, int'({phy_rst_n, ctrl_rst_n, user_rst_n, ddr_init_done, init_err}),
          int'(o));
   endtask

   typedef struct {
      int         n;
      logic       r, l, p, c;
      int         st;
      logic [4:0] outs;   // phy, ctrl, user, done, err
   } vec_t;

   vec_t tbl[13];

   initial begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);

      // Nominal sequence with a dropped init-done after acceptance.
      tbl[0]  = '{2,  1'b0, 1'b0, 1'b0, 1'b0, 0, 5'b00000};
      tbl[1]  = '{3,  1'b1, 1'b0, 1'b0, 1'b0, 0, 5'b00000};
      tbl[2]  = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 1, 5'b00000};
      tbl[3]  = '{15, 1'b1, 1'b1, 1'b0, 1'b0, 1, 5'b00000};
      tbl[4]  = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 2, 5'b10000};
      tbl[5]  = '{5,  1'b1, 1'b1, 1'b0, 1'b0, 2, 5'b10000};
      tbl[6]  = '{1,  1'b1, 1'b1, 1'b1, 1'b0, 3, 5'b11000};
      tbl[7]  = '{3,  1'b1, 1'b1, 1'b0, 1'b0, 3, 5'b11000};
      tbl[8]  = '{1,  1'b1, 1'b1, 1'b0, 1'b1, 4, 5'b11000};
      tbl[9]  = '{7,  1'b1, 1'b1, 1'b0, 1'b0, 4, 5'b11000};
      tbl[10] = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 5, 5'b11110};
      tbl[11] = '{4,  1'b1, 1'b1, 1'b0, 1'b0, 5, 5'b11110};
      tbl[12] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 0, 5'b00000};

      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].r, tbl[i].l, tbl[i].p, tbl[i].c);
         ticks(tbl[i].n);
         chk_outs($sformatf("tbl%0d", i), tbl[i].st, tbl[i].outs);
      end

      // Lock glitch during debounce restarts the full debounce.
      drive(1'b1, 1'b1, 1'b0, 1'b0); ticks(10);
      chk_outs("glitch_pre", 1, 5'b00000);
      drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
      chk_outs("glitch_drop", 0, 5'b00000);
      drive(1'b1, 1'b1, 1'b0, 1'b0); ticks(16);
      chk_outs("glitch_15", 1, 5'b00000);
      tick();
      chk_outs("glitch_phy", 2, 5'b10000);

      // PHY timeout, sticky error, cleared by lock loss.
      ticks(TO - 1);
      chk_outs("to_last", 2, 5'b10000);
      tick();
      chk_outs("to_err", 6, 5'b00001);
      drive(1'b1, 1'b1, 1'b1, 1'b1); ticks(5);
      chk_outs("to_sticky", 6, 5'b00001);
      drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
      chk_outs("to_clear", 0, 5'b00000);

      // phy_init_done rising on the timeout edge wins.
      drive(1'b1, 1'b1, 1'b0, 1'b0); ticks(1 + LS + TO - 1);
      chk_outs("sim_pre", 2, 5'b10000);
      drive(1'b1, 1'b1, 1'b1, 1'b0); tick();
      chk_outs("sim_phy", 3, 5'b11000);

      // Lock loss on the same edge as ctrl_init_done wins.
      drive(1'b1, 1'b0, 1'b0, 1'b1); tick();
      chk_outs("sim_lock", 0, 5'b00000);

      // phy_init_done already high before PHY_WAIT: acted on one edge after entry.
      drive(1'b1, 1'b1, 1'b1, 1'b0); ticks(1 + LS);
      chk_outs("early_phy", 2, 5'b10000);
      tick();
      chk_outs("early_ctrl", 3, 5'b11000);

      // Reset while in USER_DLY, then a full restart.
      drive(1'b1, 1'b1, 1'b0, 1'b1); tick();
      ticks(3);
      chk_outs("rst_udly", 4, 5'b11000);
      drive(1'b0, 1'b1, 1'b1, 1'b1); tick();
      chk_outs("rst_mid", 0, 5'b00000);
      drive(1'b1, 1'b1, 1'b1, 1'b1); ticks(1 + LS + 1 + 1 + UD);
      chk_outs("rst_restart", 5, 5'b11110);

      // Randomized run against the model.
      for (int seg = 0; seg < 60; seg++) begin
         int lock_pct, done_pct;
         lock_pct = 96 + int'($urandom_range(0, 4));
         done_pct = int'($urandom_range(2, 20));
         for (int i = 0; i < 50; i++) begin
            drive($urandom_range(0, 199) != 0,
                  int'($urandom_range(0, 99)) < lock_pct,
                  int'($urandom_range(0, 99)) < done_pct,
                  int'($urandom_range(0, 99)) < done_pct);
            tick();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
